stopwatch_ctrl_fsm: RTL and testbench

Control stage directly upstream of the stopwatch time counter. It synchronises and debounces the two board push buttons (start/stop, clear) and produces one-cycle press pulses. A Moore FSM turns those pulses into the 2-bit cnt_ctrl command (IDLE/COUNT/PAUSE) that the counter consumes. Runs on the 50 MHz system clock.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 69 ++++++
 rtl/stopwatch_ctrl_fsm.sv | 83 ++++++++
 tb/tb_stopwatch_ctrl_fsm.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch control path and the time counter:
//   - cnt_ctrl_e : 2-bit command encoding consumed by the time counter
//   - CLK_HZ     : system clock frequency
//   - DB_CYCLES_DEFAULT : default debounce window (20 ms at CLK_HZ)
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int CLK_HZ            = 50_000_000;
    localparam int DB_CYCLES_DEFAULT = 1_000_000;
    localparam int DB_W_DEFAULT      = 24;

    // The counter decodes these exact values; 2'b11 is illegal.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        PAUSE = 2'b10
    } cnt_ctrl_e;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises an asynchronous active-low push button, debounces it and emits
// a one-cycle pulse on every accepted press (release produces no pulse).
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   btn_n_i  : raw button, active-low, asynchronous to clk
//   press_o  : one-cycle pulse in the cycle after the debounced level rises
// A level change is accepted only after DB_CYCLES consecutive cycles in which
// the synchronised level differs from the debounced level.
// -----------------------------------------------------------------------------
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int DB_W      = DB_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            db_q, db_d;
    logic            db_dly_q;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            level_pressed;

    // Synchronised level, inverted so 1 means pressed.
    assign level_pressed = ~sync_q[1];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        db_d  = db_q;
        if (level_pressed == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // This edge would make the count reach DB_CYCLES: accept the level.
            db_d  = level_pressed;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], btn_n_i};
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = db_q & ~db_dly_q;

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_fsm
// Turns the start/stop and clear push buttons into the cnt_ctrl command for
// the stopwatch time counter.
//   clk         : 50 MHz system clock
//   rst         : asynchronous active-high reset
//   btn_start_n : start/stop button, active-low, asynchronous
//   btn_clear_n : clear button, active-low, asynchronous
//   cnt_ctrl    : registered command, IDLE/COUNT/PAUSE (stopwatch_pkg)
//   run_led     : registered, high exactly while cnt_ctrl == COUNT
// Moore FSM: IDLE -start-> COUNT -start-> PAUSE; PAUSE -clear-> IDLE,
// PAUSE -start-> COUNT. Clear is ignored unless paused and wins over start
// when both pulse together in PAUSE.
// -----------------------------------------------------------------------------
module stopwatch_ctrl_fsm
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int DB_W      = DB_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_n,
    input  logic       btn_clear_n,
    output logic [1:0] cnt_ctrl,
    output logic       run_led
);

    logic      start_pulse;
    logic      clear_pulse;
    cnt_ctrl_e state_q, state_d;
    logic      run_led_q, run_led_d;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_start (
        .clk     (clk),
        .rst     (rst),
        .btn_n_i (btn_start_n),
        .press_o (start_pulse)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_n_i (btn_clear_n),
        .press_o (clear_pulse)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_pulse) state_d = COUNT;
            COUNT:   if (start_pulse) state_d = PAUSE;
            PAUSE: begin
                if (clear_pulse)      state_d = IDLE;
                else if (start_pulse) state_d = COUNT;
            end
            // 2'b11 (upset or X) recovers to IDLE on the next edge.
            default: state_d = IDLE;
        endcase
        // Registered alongside the state so the LED has no decode glitches.
        run_led_d = (state_d == COUNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            run_led_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_led_q <= run_led_d;
        end
    end

    assign cnt_ctrl = state_q;
    assign run_led  = run_led_q;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl_fsm
// Self-checking bench for stopwatch_ctrl_fsm with DB_CYCLES = 4, DB_W = 3.
// Inputs change and outputs are sampled on the falling edge of clk.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl_fsm;
    import stopwatch_pkg::*;

    localparam int DB_CYCLES = 4;
    localparam int DB_W      = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start_n;
    logic       btn_clear_n;
    logic [1:0] cnt_ctrl;
    logic       run_led;

    int n_vec  = 0;
    int n_miss = 0;

    stopwatch_ctrl_fsm #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_start_n (btn_start_n),
        .btn_clear_n (btn_clear_n),
        .cnt_ctrl    (cnt_ctrl),
        .run_led     (run_led)
    );

    always #10 clk = ~clk;

    typedef struct {
        string      name;
        logic       start_n;
        logic       clear_n;
        int         cycles;
        logic [1:0] exp_ctrl;
        logic       exp_led;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [1:0] exp_ctrl, input logic exp_led);
        n_vec++;
        if (cnt_ctrl !== exp_ctrl || run_led !== exp_led) begin
            n_miss++;
            $display("FAIL %s: cnt_ctrl=%b run_led=%b, expected cnt_ctrl=%b run_led=%b",
                     name, cnt_ctrl, run_led, exp_ctrl, exp_led);
        end
    endtask

    // Drive at a falling edge, then let n rising edges pass; ends on a falling edge.
    task automatic drive(input logic s_n, input logic c_n, input int n);
        btn_start_n = s_n;
        btn_clear_n = c_n;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_start_n = 1'b1;
        btn_clear_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        btn_start_n = 1'b1;
        btn_clear_n = 1'b1;
        do_reset();
        check("reset_state", IDLE, 1'b0);

        // Start latency: button low before edge N; state changes at edge N+6.
        btn_start_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("latency_edge_N+%0d", k), (k >= 6) ? COUNT : IDLE, (k >= 6));
        end
        drive(1'b1, 1'b1, 12);
        check("latency_release", COUNT, 1'b1);

        // Asynchronous reset while counting, also mid-debounce of start.
        btn_start_n = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        #1 check("reset_async", IDLE, 1'b0);
        btn_start_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("reset_hold_idle", IDLE, 1'b0);

        // Bounce rejection: 3 low / 1 high, five times.
        for (int r = 0; r < 5; r++) begin
            drive(1'b0, 1'b1, 3);
            drive(1'b1, 1'b1, 1);
            check($sformatf("bounce_rep%0d", r), IDLE, 1'b0);
        end
        drive(1'b1, 1'b1, 8);
        check("bounce_settled", IDLE, 1'b0);
        drive(1'b0, 1'b1, 10);
        check("clean_press_after_bounce", COUNT, 1'b1);
        drive(1'b1, 1'b1, 12);

        // Table-driven full cycle, clear-ignored and simultaneous-press cases.
        do_reset();
        vecs.push_back('{"idle_released",      1'b1, 1'b1, 12, IDLE,  1'b0});
        vecs.push_back('{"start_idle",         1'b0, 1'b1, 10, COUNT, 1'b1});
        vecs.push_back('{"release_count",      1'b1, 1'b1, 12, COUNT, 1'b1});
        vecs.push_back('{"clear_in_count",     1'b1, 1'b0, 10, COUNT, 1'b1});
        vecs.push_back('{"release_count2",     1'b1, 1'b1, 12, COUNT, 1'b1});
        vecs.push_back('{"start_count",        1'b0, 1'b1, 10, PAUSE, 1'b0});
        vecs.push_back('{"release_pause",      1'b1, 1'b1, 12, PAUSE, 1'b0});
        vecs.push_back('{"clear_pause",        1'b1, 1'b0, 10, IDLE,  1'b0});
        vecs.push_back('{"release_idle",       1'b1, 1'b1, 12, IDLE,  1'b0});
        vecs.push_back('{"clear_in_idle",      1'b1, 1'b0, 10, IDLE,  1'b0});
        vecs.push_back('{"release_idle2",      1'b1, 1'b1, 12, IDLE,  1'b0});
        vecs.push_back('{"both_in_idle",       1'b0, 1'b0, 10, COUNT, 1'b1});
        vecs.push_back('{"release_count3",     1'b1, 1'b1, 12, COUNT, 1'b1});
        vecs.push_back('{"start_to_pause",     1'b0, 1'b1, 10, PAUSE, 1'b0});
        vecs.push_back('{"release_pause2",     1'b1, 1'b1, 12, PAUSE, 1'b0});
        vecs.push_back('{"start_pause_resume", 1'b0, 1'b1, 10, COUNT, 1'b1});
        vecs.push_back('{"release_count4",     1'b1, 1'b1, 12, COUNT, 1'b1});
        vecs.push_back('{"start_to_pause2",    1'b0, 1'b1, 10, PAUSE, 1'b0});
        vecs.push_back('{"release_pause3",     1'b1, 1'b1, 12, PAUSE, 1'b0});
        vecs.push_back('{"both_in_pause",      1'b0, 1'b0, 10, IDLE,  1'b0});
        vecs.push_back('{"release_final",      1'b1, 1'b1, 12, IDLE,  1'b0});
        foreach (vecs[i]) begin
            drive(vecs[i].start_n, vecs[i].clear_n, vecs[i].cycles);
            check(vecs[i].name, vecs[i].exp_ctrl, vecs[i].exp_led);
        end

        // Illegal encoding recovers to IDLE on the next edge.
        drive(1'b0, 1'b1, 10);
        check("pre_illegal_count", COUNT, 1'b1);
        drive(1'b1, 1'b1, 12);
        force dut.state_q = cnt_ctrl_e'(2'b11);
        #1 release dut.state_q;
        @(negedge clk);
        check("illegal_to_idle", IDLE, 1'b0);
        repeat (4) @(negedge clk);
        check("illegal_stays_idle", IDLE, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
